prbs_checker: RTL
=================

# prbs_checker

Receive-side companion to the random bit generator: consumes a serial PRBS bit stream, self-synchronises a local LFSR to it, then flags and counts every bit that departs from the expected sequence. It sits at the sink end of any link or loopback driven by the generator and provides lock status and bit-error statistics for link bring-up and BER measurement.

## Interface
- LFSR_W, 7, LFSR length (PRBS7 by default)
- TAP_A, 7, first feedback tap (1-based stage index)
- TAP_B, 6, second feedback tap (1-based stage index)
- LOCK_CNT, 16, consecutive matching bits required to declare lock
- LOSS_ERRS, 4, errors within one loss window that drop lock
- LOSS_WIN, 32, loss-window length in valid bits
- ERR_W, 16, width of error counter
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- bit_in  in  1  received PRBS bit
- bit_valid  in  1  bit_in is sampled on clocks where this is high
- err_clr  in  1  synchronous clear of err_count
- locked  out  1  checker is synchronised
- err_pulse  out  1  one-cycle flag: the previous valid bit mismatched while locked
- err_count  out  ERR_W  saturating count of mismatches seen while locked

## Operation
- Expected bit = sr[TAP_A-1] ^ sr[TAP_B-1]; sr shifts left, new bit enters sr[0]. Only bit_valid cycles advance any state.
- States: FILL, HUNT, LOCKED.
- FILL: received bits shifted into sr; fill counter counts to LFSR_W, then -> HUNT. No comparisons.
- HUNT: compare bit_in with expected; sr is fed from bit_in (self-sync). Match increments match_cnt, mismatch clears it. Match with sr all-zero also clears match_cnt (zero stream never locks). match_cnt reaching LOCK_CNT -> LOCKED, loss counters cleared.
- LOCKED: sr fed from expected bit (free-running, not from bit_in). Mismatch -> err_pulse, err_count +1 (saturate at all-ones), win_err +1. win_pos counts valid bits modulo LOSS_WIN; at wrap, win_err clears. win_err reaching LOSS_ERRS -> FILL, match_cnt cleared, err_count retained.
- err_clr zeroes err_count; if a mismatch occurs in the same cycle, err_count becomes 1 (increment wins over clear).
- Errors in FILL/HUNT are never counted.

## Timing
- Reset values: locked=0, err_pulse=0, err_count=0, state=FILL, sr=0, all internal counters 0.
- All outputs registered. locked rises the clock after the LOCK_CNT-th matching valid bit; falls the clock after the LOSS_ERRS-th in-window error.
- err_pulse high exactly one cycle, the cycle after the mismatching valid bit; low whenever bit_valid was low.
- Minimum lock latency: LFSR_W + LOCK_CNT valid bits (23 with defaults).
- bit_valid may be deasserted arbitrarily; state freezes, outputs hold except err_pulse returns to 0.
- reset_n assertion mid-stream immediately returns every output to its reset value.

## Configuration
- PRBS_CHK_BIT_COUNT_EN defined: adds output bit_count (out, 32) counting valid bits received while locked, saturating, cleared by err_clr together with err_count; enables BER = err_count/bit_count.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Shared package prbs_pkg: state enum (FILL, HUNT, LOCKED), default PRBS7 tap constants, shared with the generator so both ends agree on polynomial.
- One sub-module natural: prbs_lfsr_step (combinational next-bit/next-state from sr and taps), reused by the generator.

## Test plan
- PRBS7 from seed 7'h01, bit_valid=1 continuously -> locked rises after 23rd bit; err_pulse never asserted across 500 bits; err_count=0.
- Locked, invert one bit at index 100 -> single err_pulse cycle after it, err_count=1, locked stays 1.
- Locked, invert 4 bits within 20 valid bits -> err_count=4, locked falls after 4th error, relocks 23 valid bits later.
- Locked, invert 3 bits each spaced 40 bits apart -> never loses lock, err_count=3.
- All-zero stream for 200 bits -> locked stays 0, err_count=0.
- bit_valid toggled 50% random during a clean stream -> same lock point in valid-bit count as test 1; assert reset_n low mid-lock -> locked=0, err_count=0 immediately; err_clr with simultaneous error -> err_count=1.

Source files
------------

// File: rtl/prbs_pkg.sv
// prbs_pkg: checker state encoding and default PRBS7 polynomial.
// The generator imports the same taps so both ends of a link agree.
package prbs_pkg;
    typedef enum logic [1:0] {FILL, HUNT, LOCKED} chk_state_e;
    localparam int PRBS7_W     = 7;
    localparam int PRBS7_TAP_A = 7;
    localparam int PRBS7_TAP_B = 6;
endpackage

// File: rtl/prbs_lfsr_step.sv
// prbs_lfsr_step: combinational one-step LFSR advance.
// It produces the feedback bit from two taps and the left-shifted next state.
module prbs_lfsr_step #(
    parameter int W     = 7,
    parameter int TAP_A = 7,
    parameter int TAP_B = 6
) (
    input  logic [W-1:0] sr_i,
    output logic         bit_o,
    output logic [W-1:0] sr_o
);
    assign bit_o = sr_i[TAP_A-1] ^ sr_i[TAP_B-1];
    assign sr_o  = {sr_i[W-2:0], bit_o};
endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS receiver with lock detection and error counting.
// Define PRBS_CHK_BIT_COUNT_EN to add the bit_count output for BER measurement.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int LFSR_W    = PRBS7_W,
    parameter int TAP_A     = PRBS7_TAP_A,
    parameter int TAP_B     = PRBS7_TAP_B,
    parameter int LOCK_CNT  = 16,
    parameter int LOSS_ERRS = 4,
    parameter int LOSS_WIN  = 32,
    parameter int ERR_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
`ifdef PRBS_CHK_BIT_COUNT_EN
    ,
    output logic [31:0]      bit_count
`endif
);
    localparam int FW = $clog2(LFSR_W + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int PW = $clog2(LOSS_WIN + 1);
    localparam int EW = $clog2(LOSS_ERRS + 1);

    chk_state_e        state_q, state_d;
    logic [LFSR_W-1:0] sr_q, sr_d, sr_next;
    logic [FW-1:0]     fill_q, fill_d;
    logic [MW-1:0]     match_q, match_d;
    logic [PW-1:0]     win_pos_q, win_pos_d;
    logic [EW-1:0]     win_err_q, win_err_d, win_err_inc;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              locked_q, err_pulse_q;
    logic              exp_bit, mism, hit, wrap, good;

    prbs_lfsr_step #(.W(LFSR_W), .TAP_A(TAP_A), .TAP_B(TAP_B)) u_step (
        .sr_i (sr_q),
        .bit_o(exp_bit),
        .sr_o (sr_next)
    );

    assign mism        = bit_in != exp_bit;
    assign hit         = bit_valid && state_q == LOCKED && mism;
    assign wrap        = win_pos_q == PW'(LOSS_WIN - 1);
    assign win_err_inc = win_err_q + EW'(mism);
    // An all-zero register predicts zeros forever, so matches there prove nothing
    assign good        = !mism && |sr_q;
    assign err_cnt_d   = hit ? (err_clr ? ERR_W'(1) : (&err_cnt_q ? err_cnt_q : err_cnt_q + 1'b1))
                             : (err_clr ? '0 : err_cnt_q);

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        fill_d    = fill_q;
        match_d   = match_q;
        win_pos_d = win_pos_q;
        win_err_d = win_err_q;
        if (bit_valid) begin
            case (state_q)
                FILL: begin
                    sr_d    = {sr_q[LFSR_W-2:0], bit_in};
                    fill_d  = fill_q == FW'(LFSR_W - 1) ? '0 : fill_q + 1'b1;
                    state_d = fill_q == FW'(LFSR_W - 1) ? HUNT : FILL;
                end
                HUNT: begin
                    sr_d    = {sr_q[LFSR_W-2:0], bit_in};
                    match_d = good ? match_q + 1'b1 : '0;
                    if (good && match_q == MW'(LOCK_CNT - 1)) begin
                        state_d   = LOCKED;
                        match_d   = '0;
                        win_pos_d = '0;
                        win_err_d = '0;
                    end
                end
                LOCKED: begin
                    sr_d      = sr_next;
                    win_pos_d = wrap ? '0 : win_pos_q + 1'b1;
                    win_err_d = wrap ? '0 : win_err_inc;
                    if (win_err_inc == EW'(LOSS_ERRS)) begin
                        state_d = FILL;
                        match_d = '0;
                        fill_d  = '0;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FILL;
            sr_q        <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_pos_q   <= '0;
            win_err_q   <= '0;
            err_cnt_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_pos_q   <= win_pos_d;
            win_err_q   <= win_err_d;
            err_cnt_q   <= err_cnt_d;
            locked_q    <= state_d == LOCKED;
            err_pulse_q <= hit;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_cnt_q;

`ifdef PRBS_CHK_BIT_COUNT_EN
    logic [31:0] bit_cnt_q, bit_cnt_d;
    logic        bit_hit;
    assign bit_hit   = bit_valid && state_q == LOCKED;
    assign bit_cnt_d = bit_hit ? (err_clr ? 32'd1 : (&bit_cnt_q ? bit_cnt_q : bit_cnt_q + 1'b1))
                               : (err_clr ? '0 : bit_cnt_q);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bit_cnt_q <= '0;
        else          bit_cnt_q <= bit_cnt_d;
    end
    assign bit_count = bit_cnt_q;
`endif
endmodule
